// File: rtl/core_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package    : core_ctrl_pkg
// Description: Shared types and constants for the core pipeline control path.
// Revision   : 1.0 - initial release
// ============================================================================
package core_ctrl_pkg;

    // Default PC / target width of the core
    localparam int c_xlen = 32;

    // Canonical RISC-V NOP (addi x0, x0, 0) that flushed pipeline registers hold
    localparam logic [31:0] c_nop_instr = 32'h0000_0013;

    // Pipeline control modes
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FREEZE = 2'd1,
        BUBBLE = 2'd2,
        REDIR  = 2'd3
    } pipe_state_e;

    // Priority resolution: memory freeze beats hazard stall, which beats any
    // redirect. A live redirect supersedes a buffered one, so REDIR is only
    // chosen when the pending entry is the sole redirect source this cycle.
    function automatic pipe_state_e pick_state(
        input logic busy,
        input logic stall,
        input logic redir_live,
        input logic pend_vld
    );
        if (busy)
            return FREEZE;
        if (stall)
            return BUBBLE;
        if (pend_vld && !redir_live)
            return REDIR;
        return RUN;
    endfunction

endpackage : core_ctrl_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module     : sat_counter
// Description: Up-counter with synchronous clear that holds at MAX_VAL.
// Revision   : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // Count up on inc, stop at MAX_VAL; clear takes precedence over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= '0;
        else if (clr)
            r_count <= '0;
        else if (inc && (r_count != MAX_VAL))
            r_count <= r_count + WIDTH'(1);
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : pipe_stall_ctrl
// Description: Converts stall requests, data-memory busy and ID-stage redirects
//              into per-stage enables, flushes and PC select; buffers one
//              redirect across a blocked front end, counts stall/flush cycles
//              and flags stall hangs.
// Revision   : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int XLEN      = c_xlen,
    parameter int CNT_W     = 32,
    parameter int MAX_STALL = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_req,
    input  logic             dmem_busy,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    output logic             pc_we,
    output logic             pc_sel,
    output logic [XLEN-1:0]  pc_target,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_we,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             hang_err
);

    localparam int c_hang_w = $clog2(MAX_STALL + 1);

    pipe_state_e         r_state;
    pipe_state_e         w_state;
    logic                r_pend_vld;
    logic [XLEN-1:0]     r_pend_tgt;
    logic                w_blocked;
    logic [c_hang_w-1:0] w_hang_cnt;
    logic                r_hang_err;

    // Mode for this cycle: a freeze persists while memory is busy, otherwise
    // the fixed priority picks the mode from live inputs and the pending entry
    always_comb begin
        w_state = RUN;
        case (r_state)
            FREEZE:  w_state = dmem_busy ? FREEZE
                                         : pick_state(dmem_busy, stall_req, redirect_valid, r_pend_vld);
            default: w_state = pick_state(dmem_busy, stall_req, redirect_valid, r_pend_vld);
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= RUN;
        else
            r_state <= w_state;
    end

    // Zero-latency output decode; everything is held inactive while in reset
    always_comb begin
        pc_we       = 1'b0;
        pc_sel      = 1'b0;
        pc_target   = '0;
        if_id_we    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        ex_mem_we   = 1'b0;
        if (rst_n) begin
            case (w_state)
                RUN: begin
                    pc_we     = 1'b1;
                    if_id_we  = 1'b1;
                    ex_mem_we = 1'b1;
                    if (redirect_valid) begin
                        pc_sel      = 1'b1;
                        pc_target   = redirect_target;
                        if_id_flush = 1'b1;
                    end
                end
                BUBBLE: begin
                    id_ex_flush = 1'b1;
                    ex_mem_we   = 1'b1;
                end
                REDIR: begin
                    pc_we       = 1'b1;
                    if_id_we    = 1'b1;
                    ex_mem_we   = 1'b1;
                    pc_sel      = 1'b1;
                    pc_target   = r_pend_tgt;
                    if_id_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_blocked = (w_state == FREEZE) || (w_state == BUBBLE);

    // Single-entry redirect buffer: newest redirect wins while blocked; it is
    // consumed (or superseded by a live redirect) on the first unblocked cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_vld <= 1'b0;
            r_pend_tgt <= '0;
        end else if (w_blocked) begin
            if (redirect_valid) begin
                r_pend_vld <= 1'b1;
                r_pend_tgt <= redirect_target;
            end
        end else begin
            r_pend_vld <= 1'b0;
        end
    end

    sat_counter #(
        .WIDTH   (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (1'b0),
        .inc     (~pc_we),
        .count   (stall_cnt)
    );

    sat_counter #(
        .WIDTH   (CNT_W)
    ) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (1'b0),
        .inc     (pc_sel),
        .count   (flush_cnt)
    );

    // Consecutive blocked cycles; any cycle the PC advances restarts the run
    sat_counter #(
        .WIDTH   (c_hang_w),
        .MAX_VAL (c_hang_w'(MAX_STALL))
    ) u_hang_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (pc_we),
        .inc     (~pc_we),
        .count   (w_hang_cnt)
    );

    // Sticky hang flag, set on the edge that completes the MAX_STALL-th blocked cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_hang_err <= 1'b0;
        else if (w_blocked && (w_hang_cnt >= c_hang_w'(MAX_STALL - 1)))
            r_hang_err <= 1'b1;
    end

    assign hang_err = r_hang_err;

endmodule : pipe_stall_ctrl
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : tb_pipe_stall_ctrl
// Description: Directed scoreboard bench for pipe_stall_ctrl.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_ctrl;

    localparam int c_max_stall = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_req;
    logic        dmem_busy;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        pc_we;
    logic        pc_sel;
    logic [31:0] pc_target;
    logic        if_id_we;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_we;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic        hang_err;

    pipe_stall_ctrl #(
        .XLEN            (32),
        .CNT_W           (32),
        .MAX_STALL       (c_max_stall)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_req       (stall_req),
        .dmem_busy       (dmem_busy),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc_we           (pc_we),
        .pc_sel          (pc_sel),
        .pc_target       (pc_target),
        .if_id_we        (if_id_we),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_we       (ex_mem_we),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .hang_err        (hang_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pc_we;
        logic        pc_sel;
        logic [31:0] pc_target;
        logic        chk_tgt;
        logic        if_id_we;
        logic        if_id_flush;
        logic        id_ex_flush;
        logic        ex_mem_we;
        logic [31:0] stall_cnt;
        logic [31:0] flush_cnt;
        logic        hang_err;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    logic        m_pend_vld = 1'b0;
    logic [31:0] m_pend     = '0;
    int          m_stall    = 0;
    int          m_flush    = 0;
    int          m_hang     = 0;
    logic        m_err      = 1'b0;

    task automatic cmp(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, name, act, exp);
        end
    endtask

    task automatic check(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
            return;
        end
        e = q.pop_front();
        cmp(tag, "pc_we",       {31'd0, pc_we},       {31'd0, e.pc_we});
        cmp(tag, "pc_sel",      {31'd0, pc_sel},      {31'd0, e.pc_sel});
        if (e.chk_tgt)
            cmp(tag, "pc_target", pc_target, e.pc_target);
        cmp(tag, "if_id_we",    {31'd0, if_id_we},    {31'd0, e.if_id_we});
        cmp(tag, "if_id_flush", {31'd0, if_id_flush}, {31'd0, e.if_id_flush});
        cmp(tag, "id_ex_flush", {31'd0, id_ex_flush}, {31'd0, e.id_ex_flush});
        cmp(tag, "ex_mem_we",   {31'd0, ex_mem_we},   {31'd0, e.ex_mem_we});
        cmp(tag, "stall_cnt",   stall_cnt,            e.stall_cnt);
        cmp(tag, "flush_cnt",   flush_cnt,            e.flush_cnt);
        cmp(tag, "hang_err",    {31'd0, hang_err},    {31'd0, e.hang_err});
    endtask

    // One clock of stimulus: drive, predict, sample mid-cycle, then advance the model
    task automatic step(input logic sr, input logic db, input logic rv, input logic [31:0] tgt, input string tag);
        exp_t e;
        @(negedge clk);
        stall_req       = sr;
        dmem_busy       = db;
        redirect_valid  = rv;
        redirect_target = tgt;

        e = '{pc_we: 1'b1, pc_sel: 1'b0, pc_target: 32'h0, chk_tgt: 1'b0,
              if_id_we: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_we: 1'b1,
              stall_cnt: m_stall, flush_cnt: m_flush, hang_err: m_err};
        if (db) begin
            e.pc_we = 1'b0; e.if_id_we = 1'b0; e.ex_mem_we = 1'b0;
            if (rv) begin m_pend_vld = 1'b1; m_pend = tgt; end
        end else if (sr) begin
            e.pc_we = 1'b0; e.if_id_we = 1'b0; e.id_ex_flush = 1'b1;
            if (rv) begin m_pend_vld = 1'b1; m_pend = tgt; end
        end else if (rv) begin
            e.pc_sel = 1'b1; e.pc_target = tgt; e.chk_tgt = 1'b1; e.if_id_flush = 1'b1;
            m_pend_vld = 1'b0;
        end else if (m_pend_vld) begin
            e.pc_sel = 1'b1; e.pc_target = m_pend; e.chk_tgt = 1'b1; e.if_id_flush = 1'b1;
            m_pend_vld = 1'b0;
        end
        q.push_back(e);
        #1;
        check(tag);

        if (!e.pc_we) begin
            m_stall++;
            if (m_hang < c_max_stall) m_hang++;
            if (m_hang >= c_max_stall) m_err = 1'b1;
        end else begin
            m_hang = 0;
        end
        if (e.pc_sel) m_flush++;
    endtask

    task automatic push_reset_exp();
        exp_t e;
        e = '{pc_we: 1'b0, pc_sel: 1'b0, pc_target: 32'h0, chk_tgt: 1'b1,
              if_id_we: 1'b0, if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_we: 1'b0,
              stall_cnt: 32'd0, flush_cnt: 32'd0, hang_err: 1'b0};
        q.push_back(e);
    endtask

    initial begin
        rst_n           = 1'b0;
        stall_req       = 1'b0;
        dmem_busy       = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;

        // In reset: everything inactive
        push_reset_exp();
        #1;
        check("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after release
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 32'h0, "idle");

        // Single-cycle hazard stall
        step(1'b1, 1'b0, 1'b0, 32'h0, "bubble1");
        step(1'b0, 1'b0, 1'b0, 32'h0, "after_bubble");

        // Unblocked redirect applied immediately
        step(1'b0, 1'b0, 1'b1, 32'h0000_0100, "redir_live");
        step(1'b0, 1'b0, 1'b0, 32'h0, "after_redir");

        // Freeze for 3 cycles with a redirect in the middle, applied on release
        step(1'b0, 1'b1, 1'b0, 32'h0, "freeze1");
        step(1'b0, 1'b1, 1'b1, 32'h0000_0200, "freeze2");
        step(1'b0, 1'b1, 1'b0, 32'h0, "freeze3");
        step(1'b0, 1'b0, 1'b0, 32'h0, "redir_pend200");
        step(1'b0, 1'b0, 1'b0, 32'h0, "after_pend200");

        // Two redirects during a bubble: newest wins, one flush
        step(1'b1, 1'b0, 1'b1, 32'h0000_0300, "bub_r300");
        step(1'b1, 1'b0, 1'b1, 32'h0000_0400, "bub_r400");
        step(1'b1, 1'b0, 1'b0, 32'h0, "bub_hold");
        step(1'b0, 1'b0, 1'b0, 32'h0, "redir_pend400");
        step(1'b0, 1'b0, 1'b0, 32'h0, "after_pend400");

        // Live redirect coinciding with pending application: live target wins
        step(1'b1, 1'b0, 1'b1, 32'h0000_0500, "bub_r500");
        step(1'b0, 1'b0, 1'b1, 32'h0000_0600, "live_over_pend");
        step(1'b0, 1'b0, 1'b0, 32'h0, "pend_dropped");

        // Freeze outranks stall and redirect
        step(1'b1, 1'b1, 1'b1, 32'h0000_0680, "freeze_prio");
        step(1'b1, 1'b0, 1'b0, 32'h0, "stall_after_freeze");
        step(1'b0, 1'b0, 1'b0, 32'h0, "redir_pend680");

        // Long stall trips the hang flag, which stays set afterwards
        for (int i = 0; i < c_max_stall; i++)
            step(1'b1, 1'b0, (i == 10), 32'h0000_0700, "long_stall");
        step(1'b0, 1'b0, 1'b0, 32'h0, "hang_set_redir700");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, "hang_sticky");

        // Reset in the middle of a stall with a buffered redirect
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, (i == 1), 32'h0000_0800, "pre_reset");
        @(negedge clk);
        rst_n          = 1'b0;
        redirect_valid = 1'b1;
        push_reset_exp();
        #1;
        check("mid_reset");
        q.delete();
        m_pend_vld = 1'b0; m_pend = '0; m_stall = 0; m_flush = 0; m_hang = 0; m_err = 1'b0;
        @(negedge clk);
        stall_req      = 1'b0;
        redirect_valid = 1'b0;
        rst_n          = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pipe_stall_ctrl
`default_nettype wire
